bubble_shift_tracker: RTL

- Front-end timing stage sitting directly upstream of the bubble data output stage (DOUT0..DOUT3 serializer); driven by the host bubble-memory controller signals nBSEN, nREPEN and nBOOTEN.
- Synchronizes those signals to MCLK and divides active shift time into bubble rotation steps.
- Maintains the minor-loop position and resolves replicator pulses into a page number.
- Emits per-step bit strobes that tell the serializer when to present the next bit.

---
 rtl/bubble_shift_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bubble_shift_tracker.sv
// Bubble shift front end: syncs host strobes, counts rotation steps, resolves pages.
// Optional BUBBLE_REP_GLITCH_FILTER_EN: accept replicator only after REP_MIN low cycles.
module bubble_shift_tracker #(
  parameter int STEP_LEN   = 1000,
  parameter int LOOP_LEN   = 2053,
  parameter int BIT_POINT  = 500,
  parameter int REP_OFFSET = 3,
  parameter int REP_MIN    = 16
) (
  input  logic        MCLK,
  input  logic        MRST,
  input  logic        nBSEN,
  input  logic        nREPEN,
  input  logic        nBOOTEN,
  output logic        SHIFTING,
  output logic        BOOT_MODE,
  output logic [11:0] POSITION,
  output logic        BIT_STB,
  output logic [11:0] PAGE,
  output logic        PAGE_STB,
  output logic        REP_ERR
);

  localparam int SW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(STEP_LEN - 1);
  localparam logic [SW-1:0] BIT_AT   = SW'(BIT_POINT);
  localparam logic [11:0]   POS_LAST = 12'(LOOP_LEN - 1);
  localparam logic [12:0]   LOOP13   = 13'(LOOP_LEN);
  localparam logic [12:0]   OFF13    = 13'(REP_OFFSET);

  if (BIT_POINT >= STEP_LEN) begin : g_bad_bit
    $error("BIT_POINT must be below STEP_LEN");
  end
  if (LOOP_LEN > 4095 || LOOP_LEN < 1) begin : g_bad_loop
    $error("LOOP_LEN out of range");
  end
  if (REP_MIN < 1 || REP_OFFSET >= LOOP_LEN) begin : g_bad_rep
    $error("REP_MIN or REP_OFFSET out of range");
  end

  logic [1:0]    bsen_s_q, bsen_s_d;
  logic [2:0]    rep_s_q, rep_s_d;
  logic [1:0]    boot_s_q, boot_s_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [11:0]   pos_q, pos_d;
  logic [11:0]   page_q, page_d;
  logic          page_stb_q, page_stb_d;
  logic          err_q, err_d;

  logic        shifting;
  logic        step_end;
  logic        rep_fall;
  logic        rep_fire;
  logic        rep_shift;
  logic [11:0] rep_pos;
  logic [12:0] page_raw;
  logic [12:0] page_mod;

`ifdef BUBBLE_REP_GLITCH_FILTER_EN
  localparam int CW = $clog2(REP_MIN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REP_MIN);
  localparam logic [CW-1:0] CNT_ACC = CW'(REP_MIN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   hold_pos_q, hold_pos_d;
  logic          hold_shift_q, hold_shift_d;
  logic          rep_low;
`endif

  always_comb begin
    bsen_s_d = {bsen_s_q[0], nBSEN};
    rep_s_d  = {rep_s_q[1:0], nREPEN};
    boot_s_d = {boot_s_q[0], nBOOTEN};

    shifting = ~bsen_s_q[1];
    step_end = shifting && (sub_q == SUB_LAST);
    rep_fall = rep_s_q[2] & ~rep_s_q[1];

    sub_d = '0;
    if (shifting && !step_end) begin
      sub_d = sub_q + 1'b1;
    end

    pos_d = pos_q;
    if (step_end) begin
      pos_d = (pos_q == POS_LAST) ? 12'd0 : pos_q + 12'd1;
    end

`ifdef BUBBLE_REP_GLITCH_FILTER_EN
    rep_low = ~rep_s_q[1];
    cnt_d   = '0;
    if (rep_low) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    hold_pos_d   = rep_fall ? pos_q : hold_pos_q;
    hold_shift_d = rep_fall ? shifting : hold_shift_q;
    // Position and shift state are frozen at the edge, judged at acceptance.
    rep_fire  = rep_low && (cnt_q == CNT_ACC);
    rep_pos   = hold_pos_d;
    rep_shift = hold_shift_d;
`else
    rep_fire  = rep_fall;
    rep_pos   = pos_q;
    rep_shift = shifting;
`endif

    page_raw = {1'b0, rep_pos} + LOOP13 - OFF13;
    page_mod = (page_raw >= LOOP13) ? page_raw - LOOP13 : page_raw;

    page_d     = page_q;
    page_stb_d = 1'b0;
    err_d      = err_q;
    if (rep_fire) begin
      if (rep_shift) begin
        page_d     = page_mod[11:0];
        page_stb_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!MRST) begin
      bsen_s_q   <= 2'b11;
      rep_s_q    <= 3'b111;
      boot_s_q   <= 2'b11;
      sub_q      <= '0;
      pos_q      <= '0;
      page_q     <= '0;
      page_stb_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bsen_s_q   <= bsen_s_d;
      rep_s_q    <= rep_s_d;
      boot_s_q   <= boot_s_d;
      sub_q      <= sub_d;
      pos_q      <= pos_d;
      page_q     <= page_d;
      page_stb_q <= page_stb_d;
      err_q      <= err_d;
    end
  end

`ifdef BUBBLE_REP_GLITCH_FILTER_EN
  always_ff @(posedge MCLK) begin
    if (!MRST) begin
      cnt_q        <= '0;
      hold_pos_q   <= '0;
      hold_shift_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hold_pos_q   <= hold_pos_d;
      hold_shift_q <= hold_shift_d;
    end
  end
`endif

  assign SHIFTING  = shifting;
  assign BOOT_MODE = ~boot_s_q[1];
  assign POSITION  = pos_q;
  assign BIT_STB   = shifting && (sub_q == BIT_AT);
  assign PAGE      = page_q;
  assign PAGE_STB  = page_stb_q;
  assign REP_ERR   = err_q;

endmodule
